pc_sequencer: RTL and testbench

- Parametrised successor to the core's program counter unit.
- Generates `prog_ctr` for `instr_ROM`.
- Supports:
  - sequential increment
  - absolute jump (PC_LUT target)
  - signed relative jump
  - subroutine call/return through an internal return-address stack
  - stall
  - sticky program-completion detection
- Replaces the fixed-compare `done` logic in top_level. The end address becomes a parameter, and completion freezes the PC.

---
 rtl/pc_sequencer.sv | 115 +++++++++++
 tb/tb_pc_sequencer.sv | 213 +++++++++++++++++++++
 2 files changed

// File: rtl/pc_sequencer.sv
// rtl/pc_sequencer.sv - program counter sequencer with jumps, call/return stack and sticky completion.
// One register stage; every output is driven directly from a flop.
module pc_sequencer #(
  parameter int D           = 10,
  parameter int OFS_W       = 6,
  parameter int STACK_DEPTH = 4,
  parameter int DONE_ADDR   = 72,
  parameter int SP_W        = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             stall,
  input  logic             absjump_en,
  input  logic             reljump_en,
  input  logic             call_en,
  input  logic             ret_en,
  input  logic             halt,
  input  logic [D-1:0]     target,
  input  logic [OFS_W-1:0] rel_offset,
  output logic [D-1:0]     prog_ctr,
  output logic             done,
  output logic [SP_W-1:0]  stack_cnt,
  output logic             stack_ovf,
  output logic             stack_unf
);

  localparam int IDX_W = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;
  localparam logic [D-1:0]    DONE_PC   = D'(DONE_ADDR);
  localparam logic [SP_W-1:0] FULL_CNT  = SP_W'(STACK_DEPTH);

  logic [D-1:0]     stack_mem [STACK_DEPTH];
  logic [D-1:0]     pc_inc;
  logic [D-1:0]     rel_ext;
  logic [SP_W-1:0]  cnt_dec;
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] rd_idx;
  logic             active;

  logic [D-1:0]     pc_nxt;
  logic [SP_W-1:0]  cnt_nxt;
  logic             done_nxt;
  logic             ovf_nxt;
  logic             unf_nxt;
  logic             push;

  assign pc_inc  = prog_ctr + D'(1);
  assign rel_ext = D'($signed(rel_offset));
  assign cnt_dec = stack_cnt - SP_W'(1);
  assign wr_idx  = IDX_W'(stack_cnt);
  assign rd_idx  = IDX_W'(cnt_dec);
  assign active  = !stall && !done;

  // Completion is judged on the current PC; the PC still advances once more before freezing.
  always_comb begin
    pc_nxt   = prog_ctr;
    cnt_nxt  = stack_cnt;
    done_nxt = done;
    ovf_nxt  = stack_ovf;
    unf_nxt  = stack_unf;
    push     = 1'b0;
    if (active) begin
      if (halt || prog_ctr == DONE_PC) begin
        done_nxt = 1'b1;
      end
      if (ret_en) begin
        if (stack_cnt != '0) begin
          pc_nxt  = stack_mem[rd_idx];
          cnt_nxt = cnt_dec;
        end else begin
          unf_nxt = 1'b1;
          pc_nxt  = pc_inc;
        end
      end else if (call_en) begin
        if (stack_cnt < FULL_CNT) begin
          push    = 1'b1;
          cnt_nxt = stack_cnt + SP_W'(1);
          pc_nxt  = target;
        end else begin
          ovf_nxt = 1'b1;
          pc_nxt  = pc_inc;
        end
      end else if (absjump_en) begin
        pc_nxt = target;
      end else if (reljump_en) begin
        pc_nxt = prog_ctr + rel_ext;
      end else begin
        pc_nxt = pc_inc;
      end
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      prog_ctr  <= '0;
      done      <= 1'b0;
      stack_cnt <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else begin
      prog_ctr  <= pc_nxt;
      done      <= done_nxt;
      stack_cnt <= cnt_nxt;
      stack_ovf <= ovf_nxt;
      stack_unf <= unf_nxt;
    end
  end

  // Stack contents need no reset; only the occupancy count is meaningful after reset.
  always_ff @(posedge clk) begin
    if (push) begin
      stack_mem[wr_idx] <= pc_inc;
    end
  end

endmodule

// File: tb/tb_pc_sequencer.sv
// tb/tb_pc_sequencer.sv - scoreboard bench for pc_sequencer against a queue-based reference model.
module tb_pc_sequencer;
  localparam int D     = 10;
  localparam int OFS_W = 6;
  localparam int DEPTH = 4;
  localparam int DADDR = 72;
  localparam int MOD   = 1 << D;
  localparam int SP_W  = $clog2(DEPTH + 1);

  logic             clk = 1'b0;
  logic             reset;
  logic             stall, absjump_en, reljump_en, call_en, ret_en, halt;
  logic [D-1:0]     target;
  logic [OFS_W-1:0] rel_offset;
  logic [D-1:0]     prog_ctr;
  logic             done;
  logic [SP_W-1:0]  stack_cnt;
  logic             stack_ovf, stack_unf;

  pc_sequencer #(.D(D), .OFS_W(OFS_W), .STACK_DEPTH(DEPTH), .DONE_ADDR(DADDR)) dut (
    .clk(clk), .reset(reset), .stall(stall), .absjump_en(absjump_en),
    .reljump_en(reljump_en), .call_en(call_en), .ret_en(ret_en), .halt(halt),
    .target(target), .rel_offset(rel_offset), .prog_ctr(prog_ctr), .done(done),
    .stack_cnt(stack_cnt), .stack_ovf(stack_ovf), .stack_unf(stack_unf)
  );

  always #5 clk = ~clk;

  typedef struct {
    int    pc;
    bit    dn;
    int    cnt;
    bit    ovf;
    bit    unf;
    string name;
  } exp_t;

  exp_t expq[$];
  event async_ev;
  int   n_tests = 0;
  int   n_fail  = 0;

  // Reference model state
  int m_pc;
  bit m_done, m_ovf, m_unf;
  int m_stk[$];

  task automatic model_reset();
    m_pc = 0; m_done = 0; m_ovf = 0; m_unf = 0;
    m_stk.delete();
  endtask

  task automatic model_step(input bit st, ab, rl, cl, rt, hl, input int tgt, input int ofs);
    int nxt;
    int sofs;
    if (st || m_done) return;
    nxt = (m_pc + 1) % MOD;
    if (hl || m_pc == DADDR) m_done = 1;
    if (rt) begin
      if (m_stk.size() > 0) m_pc = m_stk.pop_back();
      else begin m_unf = 1; m_pc = nxt; end
    end else if (cl) begin
      if (m_stk.size() < DEPTH) begin m_stk.push_back(nxt); m_pc = tgt; end
      else begin m_ovf = 1; m_pc = nxt; end
    end else if (ab) begin
      m_pc = tgt;
    end else if (rl) begin
      sofs = (ofs >= (1 << (OFS_W - 1))) ? ofs - (1 << OFS_W) : ofs;
      m_pc = ((m_pc + sofs) % MOD + MOD) % MOD;
    end else begin
      m_pc = nxt;
    end
  endtask

  task automatic push_exp(input string nm);
    exp_t e;
    e.pc = m_pc; e.dn = m_done; e.cnt = m_stk.size(); e.ovf = m_ovf; e.unf = m_unf; e.name = nm;
    expq.push_back(e);
  endtask

  task automatic cyc(input bit st, ab, rl, cl, rt, hl, input int tgt, input int ofs, input string nm);
    @(negedge clk);
    reset = 1'b0;
    stall = st; absjump_en = ab; reljump_en = rl; call_en = cl; ret_en = rt; halt = hl;
    target = D'(tgt); rel_offset = OFS_W'(ofs);
    model_step(st, ab, rl, cl, rt, hl, tgt, ofs);
    push_exp(nm);
  endtask

  task automatic idle(input int n, input string nm);
    for (int i = 0; i < n; i++) cyc(0, 0, 0, 0, 0, 0, 0, 0, nm);
  endtask

  task automatic jmp(input int tgt, input string nm);
    cyc(0, 1, 0, 0, 0, 0, tgt, 0, nm);
  endtask

  // Reset asserted between edges; the monitor checks the outputs before the next rising edge.
  task automatic do_reset(input string nm);
    @(posedge clk);
    #3;
    reset = 1'b1;
    model_reset();
    push_exp(nm);
    -> async_ev;
    @(negedge clk);
    stall = 0; absjump_en = 0; reljump_en = 0; call_en = 0; ret_en = 0; halt = 0;
    push_exp({nm, "_held"});
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(posedge clk or async_ev);
      #1;
      if (expq.size() > 0) begin
        e = expq.pop_front();
        n_tests++;
        if (int'(prog_ctr) !== e.pc || done !== e.dn || int'(stack_cnt) !== e.cnt ||
            stack_ovf !== e.ovf || stack_unf !== e.unf) begin
          n_fail++;
          $display("FAIL %s: got pc=%0d done=%0d cnt=%0d ovf=%0d unf=%0d, expected pc=%0d done=%0d cnt=%0d ovf=%0d unf=%0d",
                   e.name, prog_ctr, done, stack_cnt, stack_ovf, stack_unf,
                   e.pc, e.dn, e.cnt, e.ovf, e.unf);
        end
      end
    end
  end

  initial begin : watchdog
    #2000000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "timeout");
  end

  initial begin : stim
    reset = 1'b1;
    stall = 0; absjump_en = 0; reljump_en = 0; call_en = 0; ret_en = 0; halt = 0;
    target = '0; rel_offset = '0;
    model_reset();
    @(negedge clk);
    push_exp("reset_state");

    // Reset mid-run, then increment
    jmp(17, "jmp17");
    do_reset("async_reset_at17");
    idle(5, "incr_after_reset");

    // Jumps and wrap
    jmp(8, "jmp8");
    jmp(1000, "abs_1000");
    jmp(1023, "jmp1023");
    idle(1, "wrap_to_0");
    jmp(20, "jmp20");
    cyc(0, 0, 1, 0, 0, 0, 0, 6'b111101, "rel_minus3");
    jmp(20, "jmp20b");
    cyc(0, 0, 1, 0, 0, 0, 0, 31, "rel_plus31");
    jmp(1020, "jmp1020");
    cyc(0, 0, 1, 0, 0, 0, 0, 10, "rel_wrap_up");
    cyc(0, 0, 1, 0, 0, 0, 0, 6'b100000, "rel_min_wrap");

    // Call/return nesting
    jmp(10, "jmp10");
    cyc(0, 0, 0, 1, 0, 0, 100, 0, "call_100");
    idle(1, "to_101");
    cyc(0, 0, 0, 1, 0, 0, 200, 0, "call_200");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, "ret_102");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, "ret_11");

    // Stack boundaries
    for (int i = 0; i < 5; i++) cyc(0, 0, 0, 1, 0, 0, 300 + 10 * i, 0, "call_chain");
    for (int i = 0; i < 4; i++) cyc(0, 0, 0, 0, 1, 0, 0, 0, "ret_chain");
    cyc(0, 0, 0, 0, 1, 0, 0, 0, "ret_empty_unf");

    // Priority and stall
    cyc(0, 0, 0, 1, 0, 0, 400, 0, "call_400");
    cyc(0, 1, 0, 1, 1, 0, 500, 0, "ret_call_abs_prio");
    cyc(0, 1, 1, 0, 0, 0, 600, 5, "abs_over_rel");
    cyc(1, 0, 0, 1, 0, 0, 700, 0, "stall_call");
    cyc(1, 0, 0, 0, 0, 1, 0, 0, "stall_halt");
    do_reset("reset_flags");

    // Completion by address, freeze, halt
    idle(73, "free_run");
    for (int i = 0; i < 10; i++) cyc(0, 1, 0, 0, 0, 0, 5, 0, "frozen_abs");
    do_reset("reset_clears_done");
    jmp(5, "jmp5");
    cyc(0, 0, 0, 0, 0, 1, 0, 0, "halt_at5");
    cyc(0, 0, 0, 1, 0, 0, 50, 0, "frozen_call");
    idle(2, "frozen_idle");
    do_reset("reset_after_halt");

    // Randomised blocks
    for (int b = 0; b < 20; b++) begin
      do_reset("rand_reset");
      for (int i = 0; i < 60; i++) begin
        cyc(($urandom % 8) == 0, ($urandom % 4) == 0, ($urandom % 3) == 0,
            ($urandom % 3) == 0, ($urandom % 3) == 0, ($urandom % 64) == 0,
            $urandom_range(0, MOD - 1), $urandom_range(0, (1 << OFS_W) - 1), "rand");
      end
    end

    repeat (3) @(posedge clk);
    #2;
    n_tests++;
    if (expq.size() != 0) begin
      n_fail++;
      $display("FAIL drain: %0d expectations left unchecked, expected 0", expq.size());
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
